// File: rtl/mux16_rr_scheduler.sv
// mux16_rr_scheduler: round-robin arbiter that drives the select lines of a
// 16:1 mux and samples the mux output while a requester holds the grant.
// A grant lasts until its request drops or HOLD_MAX cycles have elapsed.
// Every grant is followed by one RELEASE cycle and one IDLE cycle.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no grant; arbitrate from ptr+1 when en is high
// GRANT   | sel/gnt drive the mux; mux_y is sampled into dout each cycle
// RELEASE | one-cycle gap; the released index becomes lowest priority
module mux16_rr_scheduler #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] req,
    input  logic        mux_y,
    output logic [3:0]  sel,
    output logic [15:0] gnt,
    output logic        busy,
    output logic        dout,
    output logic        dout_vld
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    state_t      state, state_nxt;
    logic [3:0]  ptr, ptr_nxt;
    logic [7:0]  hold_cnt, hold_nxt;
    logic [3:0]  sel_nxt;
    logic [15:0] gnt_nxt;
    logic        busy_nxt;
    logic        dout_nxt;
    logic        dout_vld_nxt;
    logic [3:0]  winner;
    logic [3:0]  cand;
    logic        found;

    // Rotating priority search: the first request after ptr wins, so the
    // index released last is the final candidate considered.
    always_comb begin
        winner = 4'd0;
        found  = 1'b0;
        cand   = 4'd0;
        for (int i = 1; i <= 16; i++) begin
            cand = ptr + 4'(i);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        hold_nxt     = hold_cnt;
        sel_nxt      = sel;
        gnt_nxt      = gnt;
        busy_nxt     = busy;
        dout_nxt     = dout;
        dout_vld_nxt = 1'b0;
        case (state)
            IDLE: begin
                gnt_nxt  = 16'd0;
                busy_nxt = 1'b0;
                if (en && found) begin
                    state_nxt = GRANT;
                    sel_nxt   = winner;
                    gnt_nxt   = 16'd1 << winner;
                    busy_nxt  = 1'b1;
                    hold_nxt  = 8'd0;
                end
            end
            GRANT: begin
                dout_nxt     = mux_y;
                dout_vld_nxt = 1'b1;
                if (hold_cnt != HOLD_LAST) begin
                    hold_nxt = hold_cnt + 8'd1;
                end
                // en is deliberately not consulted: a grant always runs to
                // completion once issued.
                if (!req[sel] || (hold_cnt == HOLD_LAST)) begin
                    state_nxt = RELEASE;
                    gnt_nxt   = 16'd0;
                    busy_nxt  = 1'b0;
                end
            end
            RELEASE: begin
                state_nxt = IDLE;
                ptr_nxt   = sel;
                gnt_nxt   = 16'd0;
                busy_nxt  = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 16'd0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any grant in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 4'hF;
            hold_cnt <= 8'd0;
            sel      <= 4'd0;
            gnt      <= 16'd0;
            busy     <= 1'b0;
            dout     <= 1'b0;
            dout_vld <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_nxt;
            sel      <= sel_nxt;
            gnt      <= gnt_nxt;
            busy     <= busy_nxt;
            dout     <= dout_nxt;
            dout_vld <= dout_vld_nxt;
        end
    end

endmodule
